// File: rtl/space_pkg.sv
// Shared definitions for the space shooter VGA pipeline: screen geometry,
// derived ship limits and the game-state encoding.
package space_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SHIP_W   = 32;

    localparam logic [10:0] SHIP_X_MAX    = 11'(H_ACTIVE - SHIP_W);
    localparam logic [10:0] SHIP_X_CENTRE = 11'((H_ACTIVE - SHIP_W) / 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_EXPLODE = 2'd2,
        ST_OVER    = 2'd3
    } game_state_e;

endpackage

// File: rtl/game_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchroniser feeding a debouncer that only
// samples on the frame tick, so bounce shorter than a frame never reaches the game.
module btn_debounce #(
    parameter int FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic btn,
    output logic level
);
    localparam int CW = $clog2(FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAMES - 1);

    logic [1:0]    sync_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Synchronise the raw button and count consecutive disagreeing frame samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= 2'b00;
            cnt_r   <= CW'(0);
            level_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], btn};
            if (sample) begin
                if (sync_r[1] != level_r) begin
                    if (cnt_r >= LAST) begin
                        level_r <= ~level_r;
                        cnt_r   <= CW'(0);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end else begin
                    cnt_r <= CW'(0);
                end
            end
        end
    end

    assign level = level_r;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game controller: frame tick, button conditioning, game FSM, ship,
// fire cooldown, lives and score. Optional macro GAME_SEQUENCER_AUTOFIRE_EN.
module game_sequencer
    import space_pkg::*;
#(
    parameter int SHIP_STEP       = 4,
    parameter int LIVES_INIT      = 3,
    parameter int FIRE_COOLDOWN   = 8,
    parameter int EXPLODE_FRAMES  = 60,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_fire,
    input  logic        hit,
    input  logic        kill,
    output logic        frame_tick,
    output logic [10:0] ship_x,
    output logic        fire_pulse,
    output logic        freeze,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score
);
    localparam int CW = $clog2(FIRE_COOLDOWN + 1);
    localparam int TW = $clog2(EXPLODE_FRAMES + 1);
    localparam logic [10:0]   STEP       = 11'(SHIP_STEP);
    localparam logic [CW-1:0] CD_LOAD    = CW'(FIRE_COOLDOWN);
    localparam logic [TW-1:0] EXP_LOAD   = TW'(EXPLODE_FRAMES);
    localparam logic [1:0]    LIVES_LOAD = 2'(LIVES_INIT);

    logic          frame_tick_r, fire_prev_r, fire_pulse_r, freeze_r, hit_pend_r;
    game_state_e   state_r, state_n;
    logic [10:0]   ship_x_r, ship_x_n;
    logic [1:0]    lives_r, lives_n;
    logic [15:0]   score_r, score_n;
    logic [CW-1:0] cooldown_r, cooldown_n;
    logic [TW-1:0] timer_r, timer_n;
    logic          hit_pend_n, fire_pulse_n;
    logic          left_deb_s, right_deb_s, fire_deb_s, fire_edge_s, fire_trig_s;

    btn_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_deb_left  (.clk(clk), .reset(reset), .sample(frame_tick_r), .btn(btn_left),  .level(left_deb_s));
    btn_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_deb_right (.clk(clk), .reset(reset), .sample(frame_tick_r), .btn(btn_right), .level(right_deb_s));
    btn_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_deb_fire  (.clk(clk), .reset(reset), .sample(frame_tick_r), .btn(btn_fire),  .level(fire_deb_s));

    // The debouncer updates on the same edge the FSM acts, so the FSM sees last frame's level
    assign fire_edge_s = fire_deb_s & ~fire_prev_r;
`ifdef GAME_SEQUENCER_AUTOFIRE_EN
    assign fire_trig_s = fire_deb_s;
`else
    assign fire_trig_s = fire_edge_s;
`endif

    // Next-state logic for the game FSM and everything it owns
    always_comb begin
        state_n      = state_r;
        ship_x_n     = ship_x_r;
        lives_n      = lives_r;
        cooldown_n   = cooldown_r;
        timer_n      = timer_r;
        fire_pulse_n = 1'b0;
        if (kill && (state_r == ST_PLAY || state_r == ST_EXPLODE) && score_r != 16'hFFFF) begin
            score_n = score_r + 16'd1;
        end else begin
            score_n = score_r;
        end
        if (state_r == ST_PLAY) begin
            hit_pend_n = hit_pend_r | hit;
        end else begin
            hit_pend_n = 1'b0;
        end
        if (frame_tick_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (fire_edge_s) state_n = ST_PLAY;
                    else             state_n = ST_IDLE;
                end
                ST_PLAY: begin
                    if (hit_pend_n) begin
                        if (lives_r != 2'd0) lives_n = lives_r - 2'd1;
                        else                 lives_n = 2'd0;
                        hit_pend_n = 1'b0;
                        timer_n    = EXP_LOAD;
                        state_n    = ST_EXPLODE;
                    end else begin
                        if (left_deb_s && !right_deb_s) begin
                            if (ship_x_r >= STEP) ship_x_n = ship_x_r - STEP;
                            else                  ship_x_n = 11'd0;
                        end else if (right_deb_s && !left_deb_s) begin
                            if (ship_x_r >= SHIP_X_MAX - STEP) ship_x_n = SHIP_X_MAX;
                            else                               ship_x_n = ship_x_r + STEP;
                        end else begin
                            ship_x_n = ship_x_r;
                        end
                        if (cooldown_r != CW'(0)) begin
                            cooldown_n = cooldown_r - CW'(1);
                        end else if (fire_trig_s) begin
                            fire_pulse_n = 1'b1;
                            cooldown_n   = CD_LOAD;
                        end else begin
                            cooldown_n = cooldown_r;
                        end
                    end
                end
                ST_EXPLODE: begin
                    // Leaving on the tick that would reach zero keeps the freeze at EXPLODE_FRAMES frames
                    if (timer_r <= TW'(1)) begin
                        timer_n = TW'(0);
                        if (lives_r == 2'd0) begin
                            state_n = ST_OVER;
                        end else begin
                            state_n    = ST_PLAY;
                            ship_x_n   = SHIP_X_CENTRE;
                            cooldown_n = CW'(0);
                        end
                    end else begin
                        timer_n = timer_r - TW'(1);
                    end
                end
                ST_OVER: begin
                    if (fire_edge_s) begin
                        state_n    = ST_IDLE;
                        lives_n    = LIVES_LOAD;
                        score_n    = 16'd0;
                        ship_x_n   = SHIP_X_CENTRE;
                        cooldown_n = CW'(0);
                    end else begin
                        state_n = ST_OVER;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Game registers, frame tick detection and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
            fire_prev_r  <= 1'b0;
            fire_pulse_r <= 1'b0;
            freeze_r     <= 1'b1;
            hit_pend_r   <= 1'b0;
            state_r      <= ST_IDLE;
            ship_x_r     <= SHIP_X_CENTRE;
            lives_r      <= LIVES_LOAD;
            score_r      <= 16'd0;
            cooldown_r   <= CW'(0);
            timer_r      <= TW'(0);
        end else begin
            frame_tick_r <= p_tick && (pixel_x == 11'd0) && (pixel_y == 11'(V_ACTIVE));
            if (frame_tick_r) fire_prev_r <= fire_deb_s;
            fire_pulse_r <= fire_pulse_n;
            freeze_r     <= (state_n != ST_PLAY);
            hit_pend_r   <= hit_pend_n;
            state_r      <= state_n;
            ship_x_r     <= ship_x_n;
            lives_r      <= lives_n;
            score_r      <= score_n;
            cooldown_r   <= cooldown_n;
            timer_r      <= timer_n;
        end
    end

    assign frame_tick = frame_tick_r;
    assign ship_x     = ship_x_r;
    assign fire_pulse = fire_pulse_r;
    assign freeze     = freeze_r;
    assign state      = state_r;
    assign lives      = lives_r;
    assign score      = score_r;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Frame-rate game controller for the space shooter VGA pipeline. It derives a one-cycle frame tick from the sync counters, debounces the board buttons, and runs the game state machine (IDLE/PLAY/EXPLODE/OVER). It owns ship position, fire scheduling with cooldown, lives and score, and drives the renderer's update/freeze controls. It sits between the button inputs, the sync block and the wall/renderer block.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SHIP_W, 32, ship width in pixels
SHIP_STEP, 4, ship move per frame, in pixels
LIVES_INIT, 3, lives at game start (max 3, fits 2 bits)
FIRE_COOLDOWN, 8, frames between shots
EXPLODE_FRAMES, 60, length of the explosion freeze, in frames
DEBOUNCE_FRAMES, 2, consecutive equal frame samples needed to change a button state

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
p_tick  in  1  pixel enable from the sync block
pixel_x  in  11  current pixel column
pixel_y  in  11  current pixel row
btn_left  in  1  raw asynchronous button
btn_right  in  1  raw asynchronous button
btn_fire  in  1  raw asynchronous button
hit  in  1  one-cycle pulse from the renderer: ship collided
kill  in  1  one-cycle pulse from the renderer: enemy destroyed
frame_tick  out  1  one-cycle pulse at frame boundary
ship_x  out  11  ship left-edge column
fire_pulse  out  1  one-cycle bullet spawn request
freeze  out  1  renderer holds motion when high
state  out  2  IDLE=0, PLAY=1, EXPLODE=2, OVER=3
lives  out  2  remaining lives
score  out  16  kill count, saturating

Behaviour:
- Reset (synchronous, active-high) applies at the next clk edge, including mid-operation. Reset values:
  - state=IDLE, ship_x=(H_ACTIVE-SHIP_W)/2=304, lives=LIVES_INIT, score=0.
  - fire_pulse=0, frame_tick=0, freeze=1.
  - cooldown=0, hit_pend=0, debounced buttons=0.
- frame_tick: registered; high for exactly one clk cycle, in the cycle after the one where p_tick=1, pixel_x=0 and pixel_y=V_ACTIVE.
- Buttons: 2-flop synchroniser, then sampled only on frame_tick. Debounced output toggles after DEBOUNCE_FRAMES consecutive samples differing from the current debounced value. Fire edge = debounced rising edge, one frame_tick wide.
- IDLE: freeze=1. Fire edge -> PLAY. This press is consumed and does not fire.
- PLAY: freeze=0. On each frame_tick:
  - Left only: ship_x = max(ship_x-SHIP_STEP, 0).
  - Right only: ship_x = min(ship_x+SHIP_STEP, H_ACTIVE-SHIP_W=608).
  - Both or neither: no move.
  - If cooldown>0, decrement it.
  - Else if fire edge: fire_pulse=1 for the cycle after frame_tick, and cooldown loads FIRE_COOLDOWN.
- Shot spacing: with FIRE_COOLDOWN=8, the next shot is allowed ≥9 frames later.
- hit (any cycle in PLAY) sets hit_pend. At frame_tick with hit_pend:
  - lives decrements (no underflow below 0), hit_pend clears, timer loads EXPLODE_FRAMES, state -> EXPLODE.
  - Movement and fire are suppressed that frame.
- kill (any cycle in PLAY or EXPLODE): score+1, saturating at 0xFFFF. A kill in the same frame as a hit still counts.
- EXPLODE: freeze=1; hit ignored; hit_pend held clear. Timer decrements each frame_tick. At timer=0:
  - lives==0 -> OVER.
  - else -> PLAY, ship_x reset to 304, cooldown=0.
- OVER: freeze=1; lives and score hold. Fire edge -> IDLE, which reloads lives=LIVES_INIT, score=0, ship_x=304.
- hit/kill received outside the listed states are ignored.

Optional Feature:
Macro: GAME_SEQUENCER_AUTOFIRE_EN
- Defined: in PLAY, a held debounced fire re-fires at every frame_tick where cooldown==0 (one shot per FIRE_COOLDOWN+1 frames).
- Undefined: each shot requires a new debounced rising edge.

Decomposition:
- Shared package space_pkg holds:
  - the game-state enum (IDLE/PLAY/EXPLODE/OVER, 2-bit);
  - geometry constants H_ACTIVE, V_ACTIVE, SHIP_W, shared with sync and wall;
  - the derived SHIP_X_MAX and SHIP_X_CENTRE.
- One sub-module, btn_debounce (synchroniser plus frame-rate counter), instantiated three times.

Test Plan:
- Reset asserted for 2 cycles mid-EXPLODE -> next edge: state=0, ship_x=304, lives=3, score=0, freeze=1, fire_pulse=0.
- Frame boundary: sweep the sync counters -> frame_tick exactly one cycle per frame, in the cycle after p_tick at (0,480); never elsewhere.
- Ship clamping:
  - Fire press to enter PLAY, then hold right 100 frames -> ship_x steps +4 per frame after 2-frame debounce latency, clamps at 608.
  - Then hold left 200 frames -> clamps at 0.
  - Both held -> ship_x unchanged.
- Cooldown (macro undefined): fire presses 3 frames apart -> one fire_pulse; a press 9 frames after the first -> second pulse; each pulse exactly 1 cycle.
- Hits to game over:
  - 3 hit pulses, each after the EXPLODE return -> lives 3→2→1→0.
  - Each EXPLODE lasts 60 frames with freeze=1.
  - After the third: state=OVER; fire -> IDLE with lives=3.
- Score: preload score via 65534 kill pulses, then 2 more kills -> score=0xFFFF. A kill and a hit in the same frame -> score+1 and lives-1 both applied.
